// File: rtl/irq_source_pkg.sv
// Shared types and constants for the irq_source timer/interrupt block.
// Register offsets, CTRL/STATUS bit positions and the FSM state encoding.
package irq_source_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_FIRE  = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_PERIOD = 3'd1;
    localparam logic [2:0] OFF_COUNT  = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;
    localparam logic [2:0] OFF_FIRES  = 3'd4;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_MODE  = 1;
    localparam int STAT_IRQ   = 0;
    localparam int STAT_MODE  = 1;
    localparam int STAT_STATE = 2;

    function automatic logic [31:0] merge_be(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_source_if.sv
// Register bus between the bridge address decoder and irq_source.
// The bridge is master; the peripheral is slave and returns rdata.
interface irq_source_if;
    logic        sel;
    logic [2:0]  addr;
    logic        we;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output sel, addr, we, byteen, wdata,
        input  rdata
    );

    modport slave (
        input  sel, addr, we, byteen, wdata,
        output rdata
    );
endinterface

// File: rtl/irq_source_regs.sv
// CTRL/PERIOD storage with byte-lane merge, plus the combinational read mux.
// EN can be cleared by the FSM when a one-shot run completes.
module irq_source_regs
    import irq_source_pkg::*;
#(
    parameter logic [31:0] PERIOD_RST = 32'd100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel_i,
    input  logic        we_i,
    input  logic [2:0]  addr_i,
    input  logic [3:0]  byteen_i,
    input  logic [31:0] wdata_i,
    input  logic        en_clr_i,
    input  state_e      state_i,
    input  logic        irq_i,
    input  logic [31:0] cnt_i,
    input  logic [31:0] fires_i,
    output logic        mode_o,
    output logic [31:0] period_o,
    output logic [31:0] rdata_o
);

    logic [1:0]  ctrl_q, ctrl_d;
    logic [31:0] period_q, period_d;
    logic [31:0] status;
    logic        wr;

    assign wr = sel_i & we_i;

    always_comb begin
        ctrl_d   = ctrl_q;
        period_d = period_q;
        if (wr && addr_i == OFF_CTRL && byteen_i[0]) begin
            ctrl_d = wdata_i[1:0];
        end
        if (wr && addr_i == OFF_PERIOD) begin
            period_d = merge_be(period_q, wdata_i, byteen_i);
        end
        // hardware clear wins over a racing CTRL write
        if (en_clr_i) ctrl_d[CTRL_EN] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q   <= 2'b00;
            period_q <= PERIOD_RST;
        end else begin
            ctrl_q   <= ctrl_d;
            period_q <= period_d;
        end
    end

    always_comb begin
        status                   = '0;
        status[STAT_IRQ]         = irq_i;
        status[STAT_MODE]        = ctrl_q[CTRL_MODE];
        status[STAT_STATE +: 2]  = state_i;
    end

    always_comb begin
        rdata_o = '0;
        case (addr_i)
            OFF_CTRL:   rdata_o = {30'b0, ctrl_q};
            OFF_PERIOD: rdata_o = period_q;
            OFF_COUNT:  rdata_o = cnt_i;
            OFF_STATUS: rdata_o = status;
            OFF_FIRES:  rdata_o = fires_i;
            default:    rdata_o = '0;
        endcase
    end

    assign mode_o   = ctrl_q[CTRL_MODE];
    assign period_o = period_q;

endmodule

// File: rtl/irq_source.sv
// Programmable one-shot/periodic interrupt source with ACK and hold-off.
// Define IRQ_SOURCE_FIRES_EN to build the FIRES event counter at offset 4.
module irq_source
    import irq_source_pkg::*;
#(
    parameter logic [31:0] PERIOD_RST = 32'd100,
    parameter int          HOLDOFF    = 4
) (
    input  logic         clk,
    input  logic         reset,
    irq_source_if.slave  bus,
    output logic         irq
);

    localparam logic [3:0] HOLD_LD = 4'(HOLDOFF);

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  hold_q, hold_d;
    logic        irq_q, irq_d;
    logic        en_clr;
    logic        mode;
    logic [31:0] period, reload, fires;
    logic        wr, ctrl_wr, en_on, en_off, ack;

    assign wr      = bus.sel & bus.we;
    assign ctrl_wr = wr & (bus.addr == OFF_CTRL) & bus.byteen[0];
    assign en_on   = ctrl_wr & bus.wdata[CTRL_EN];
    assign en_off  = ctrl_wr & ~bus.wdata[CTRL_EN];
    assign ack     = wr & (bus.addr == OFF_STATUS) & (|bus.byteen);
    assign reload  = (period == 32'd0) ? 32'd1 : period;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        irq_d   = irq_q;
        en_clr  = 1'b0;
        if (en_off) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            hold_d  = '0;
            irq_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (en_on) begin
                        state_d = ST_COUNT;
                        cnt_d   = reload;
                    end
                end
                ST_COUNT: begin
                    if (cnt_q <= 32'd1) begin
                        state_d = ST_FIRE;
                        cnt_d   = '0;
                        irq_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                ST_FIRE: begin
                    if (ack) begin
                        state_d = ST_HOLD;
                        irq_d   = 1'b0;
                        hold_d  = HOLD_LD;
                    end
                end
                ST_HOLD: begin
                    if (hold_q <= 4'd1) begin
                        hold_d = '0;
                        if (mode) begin
                            state_d = ST_COUNT;
                            cnt_d   = reload;
                        end else begin
                            state_d = ST_IDLE;
                            en_clr  = 1'b1;
                        end
                    end else begin
                        hold_d = hold_q - 4'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            irq_q   <= irq_d;
        end
    end

`ifdef IRQ_SOURCE_FIRES_EN
    logic [31:0] fires_q, fires_d;
    logic        fires_clr;

    assign fires_clr = wr & (bus.addr == OFF_FIRES);

    always_comb begin
        fires_d = fires_q;
        if (fires_clr) begin
            fires_d = '0;
        end else if (state_q == ST_COUNT && state_d == ST_FIRE) begin
            fires_d = fires_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) fires_q <= '0;
        else        fires_q <= fires_d;
    end

    assign fires = fires_q;
`else
    assign fires = '0;
`endif

    irq_source_regs #(
        .PERIOD_RST (PERIOD_RST)
    ) u_regs (
        .clk      (clk),
        .reset    (reset),
        .sel_i    (bus.sel),
        .we_i     (bus.we),
        .addr_i   (bus.addr),
        .byteen_i (bus.byteen),
        .wdata_i  (bus.wdata),
        .en_clr_i (en_clr),
        .state_i  (state_q),
        .irq_i    (irq_q),
        .cnt_i    (cnt_q),
        .fires_i  (fires),
        .mode_o   (mode),
        .period_o (period),
        .rdata_o  (bus.rdata)
    );

    assign irq = irq_q;

endmodule

// File: tb/tb_irq_source.sv
// Scoreboard bench for irq_source: a cycle-time reference model queues
// expected irq/rdata per cycle; a negedge monitor pops and compares.
module tb_irq_source;

    localparam int          H  = 4;
    localparam logic [31:0] PR = 32'd100;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic irq;

    irq_source_if bus ();

    irq_source #(
        .PERIOD_RST (PR),
        .HOLDOFF    (H)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        irq;
        logic [2:0]  addr;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    // Model: phase uses the STATUS encoding; times are absolute cycle stamps.
    bit          m_en, m_mode;
    logic [31:0] m_period, m_fires;
    int          m_ph;
    longint      now, t_fire, t_hold;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endfunction

    function automatic void m_reset();
        m_en     = 1'b0;
        m_mode   = 1'b0;
        m_period = PR;
        m_fires  = '0;
        m_ph     = 0;
        now      = 0;
        t_fire   = 0;
        t_hold   = 0;
    endfunction

    function automatic logic [31:0] m_read(logic [2:0] a);
        logic [31:0] v;
        v = '0;
        case (a)
            3'd0: v = {30'b0, m_mode, m_en};
            3'd1: v = m_period;
            3'd2: v = (m_ph == 1) ? 32'(t_fire - now) : 32'd0;
            3'd3: v = {28'b0, 2'(m_ph), m_mode, (m_ph == 2)};
            3'd4: v = m_fires;
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic longint ival();
        return (m_period == 0) ? 64'd1 : longint'(m_period);
    endfunction

    function automatic void m_edge(bit s, bit w, logic [2:0] a,
                                   logic [3:0] be, logic [31:0] wd);
        bit     wr, cw, ack, hwclr, fire;
        int     nph;
        longint nx;
        wr    = s && w;
        cw    = wr && a == 3'd0 && be[0];
        ack   = wr && a == 3'd3 && be != 4'd0;
        hwclr = 1'b0;
        fire  = 1'b0;
        nph   = m_ph;
        nx    = now + 1;
        if (cw && !wd[0]) begin
            nph = 0;
        end else begin
            case (m_ph)
                0: if (cw) begin nph = 1; t_fire = nx + ival(); end
                1: if (nx == t_fire) begin nph = 2; fire = 1'b1; end
                2: if (ack) begin nph = 3; t_hold = nx + H; end
                default: if (nx == t_hold) begin
                    if (m_mode) begin nph = 1; t_fire = nx + ival(); end
                    else begin nph = 0; hwclr = 1'b1; end
                end
            endcase
        end
        if (cw) begin m_en = wd[0]; m_mode = wd[1]; end
        if (hwclr) m_en = 1'b0;
        if (wr && a == 3'd1) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) m_period[8*i +: 8] = wd[8*i +: 8];
        end
`ifdef IRQ_SOURCE_FIRES_EN
        if (wr && a == 3'd4) m_fires = '0;
        else if (fire) m_fires = m_fires + 32'd1;
`endif
        m_ph = nph;
        now  = nx;
    endfunction

    task automatic step(bit s, bit w, logic [2:0] a,
                        logic [3:0] be, logic [31:0] wd);
        exp_t e;
        bus.sel    = s;
        bus.we     = w;
        bus.addr   = a;
        bus.byteen = be;
        bus.wdata  = wd;
        e.rd   = m_read(a);
        e.irq  = (m_ph == 2);
        e.addr = a;
        exp_q.push_back(e);
        m_edge(s, w, a, be, wd);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(logic [2:0] a);
        step(1'b0, 1'b0, a, 4'h0, 32'h0);
    endtask

    task automatic wr(logic [2:0] a, logic [3:0] be, logic [31:0] wd);
        step(1'b1, 1'b1, a, be, wd);
    endtask

    task automatic wait_ph(int ph, int maxc);
        int k;
        k = 0;
        while (m_ph != ph && k < maxc) begin
            idle(3'd3);
            k++;
        end
        if (m_ph != ph) begin
            n_tot++;
            $display("FAIL wait_phase: phase %0d want %0d", m_ph, ph);
        end
    endtask

    task automatic reset_mid(string nm);
        bus.sel = 1'b0;
        bus.we  = 1'b0;
        #2 reset = 1'b0;
        #1 chk({nm, "_irq_async"}, {31'b0, irq}, 32'd0);
        m_reset();
        for (int a = 0; a < 5; a++) begin
            bus.addr = 3'(a);
            #1 chk($sformatf("%s_rst_reg%0d", nm, a), bus.rdata, m_read(3'(a)));
        end
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("irq", {31'b0, irq}, {31'b0, e.irq});
            chk($sformatf("rdata@%0d", e.addr), bus.rdata, e.rd);
        end
    end

    initial begin
        int r;
        bus.sel    = 1'b0;
        bus.we     = 1'b0;
        bus.addr   = '0;
        bus.byteen = '0;
        bus.wdata  = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        for (int a = 0; a < 8; a++) idle(3'(a));

        // one-shot, PERIOD=5
        wr(3'd1, 4'hF, 32'd5);
        wr(3'd0, 4'hF, 32'd1);
        wait_ph(2, 20);
        idle(3'd3);
        idle(3'd2);
        wr(3'd3, 4'hF, 32'd0);
        wait_ph(0, 20);
        idle(3'd0);
        idle(3'd3);

        // periodic, PERIOD=3, ACK two cycles after each fire
        wr(3'd1, 4'hF, 32'd3);
        wr(3'd4, 4'hF, 32'd0);
        wr(3'd0, 4'hF, 32'd3);
        repeat (3) begin
            wait_ph(2, 30);
            idle(3'd4);
            idle(3'd4);
            wr(3'd3, 4'h1, 32'd1);
        end
        wait_ph(2, 30);
        wr(3'd0, 4'h1, 32'd0);
        idle(3'd4);
        idle(3'd3);

        // PERIOD=0 behaves as 1
        wr(3'd1, 4'hF, 32'd0);
        wr(3'd0, 4'hF, 32'd1);
        idle(3'd2);
        idle(3'd3);
        wr(3'd3, 4'hF, 32'd0);
        wait_ph(0, 20);
        idle(3'd0);

        // EN=0 in FIRE goes straight to IDLE; a following ACK is ignored
        wr(3'd1, 4'hF, 32'd2);
        wr(3'd0, 4'hF, 32'd1);
        wait_ph(2, 20);
        wr(3'd0, 4'h1, 32'd0);
        wr(3'd3, 4'hF, 32'd1);
        repeat (3) idle(3'd3);

        // PERIOD change mid-count applies at the next reload
        wr(3'd1, 4'hF, 32'd20);
        wr(3'd0, 4'hF, 32'd3);
        repeat (5) idle(3'd2);
        wr(3'd1, 4'hF, 32'd10);
        wait_ph(2, 40);
        idle(3'd3);
        wr(3'd3, 4'hF, 32'd0);
        wait_ph(2, 40);
        wr(3'd0, 4'h1, 32'd0);
        idle(3'd0);

        // byte-lane merge and byteen=0 no-op
        wr(3'd1, 4'hF, 32'h100);
        wr(3'd1, 4'b0001, 32'hFF);
        idle(3'd1);
        wr(3'd1, 4'h0, 32'hDEAD_BEEF);
        idle(3'd1);
        wr(3'd6, 4'hF, 32'h1234_5678);
        idle(3'd6);
        wr(3'd1, 4'hF, 32'd4);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                idle(3'($urandom_range(0, 7)));
            end else if (r == 4) begin
                wr(3'd0, 4'($urandom_range(0, 15)),
                   32'($urandom_range(0, 3)) | 32'($urandom_range(0, 3) != 0));
            end else if (r == 5) begin
                wr(3'd1, ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF,
                   32'($urandom_range(0, 12)));
            end else if (r <= 7) begin
                wr(3'd3, 4'($urandom_range(0, 15)), $urandom);
            end else if (r == 8) begin
                wr(3'd4, 4'($urandom_range(0, 15)), $urandom);
            end else begin
                wr(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                   32'($urandom_range(0, 7)));
            end
        end

        // async reset while counting, then while firing
        wr(3'd0, 4'h1, 32'd0);
        wr(3'd1, 4'hF, 32'd10);
        wr(3'd0, 4'hF, 32'd1);
        repeat (3) idle(3'd2);
        reset_mid("count");
        idle(3'd3);
        wr(3'd1, 4'hF, 32'd2);
        wr(3'd0, 4'hF, 32'd3);
        wait_ph(2, 20);
        idle(3'd3);
        reset_mid("fire");
        idle(3'd3);
        idle(3'd0);

        bus.sel = 1'b0;
        bus.we  = 1'b0;
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
